// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption key scheduler: expands the cipher key forward to round 10,
// then streams round keys 10..0 backward over a valid/ready handshake.
module aes_inv_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box = affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_src, sub_res, g_word;
    logic [3:0]  rcon_idx;
    logic [127:0] fwd_key, inv_key;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] i0, i1, i2, i3;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // One SubWord is shared: forward step feeds w3, inverse step feeds the new w3.
    assign sub_src  = (state_q == EMIT) ? (w3 ^ w2) : w3;
    assign sub_res  = {sbox(sub_src[23:16]), sbox(sub_src[15:8]),
                       sbox(sub_src[7:0]),   sbox(sub_src[31:24])};
    assign rcon_idx = (state_q == EMIT) ? rnd_q : rnd_q + 4'd1;
    assign g_word   = sub_res ^ {rcon(rcon_idx), 24'h000000};

    assign f0 = w0 ^ g_word;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;
    assign i0 = w0 ^ g_word;
    assign inv_key = {i0, i1, i2, i3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    rnd_d   = 4'd0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                key_d = fwd_key;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd9) state_d = EMIT;
            end
            EMIT: begin
                if (rk_ready) begin
                    if (rnd_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = inv_key;
                        rnd_d = rnd_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rk_valid = (state_q == EMIT);
    assign rk_out   = key_q;
    assign rk_round = rnd_q;
    assign done     = done_q;

endmodule
